// File: rtl/alu_op_sequencer.sv
// Front-panel sequencer for the 4-bit ALU: debounces the load/abort buttons,
// captures A, B and op from the switches, runs one evaluation and holds the result.
module alu_op_sequencer #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       btnC,
    input  logic       btnU,
    input  logic       btnL,
    input  logic [3:0] sw,
    input  logic [4:0] alu_y,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [2:0] op,
    output logic [4:0] result,
    output logic       done,
    output logic [4:0] state
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [4:0] {
        LoadA  = 5'b00001,
        LoadB  = 5'b00010,
        LoadOp = 5'b00100,
        Exec   = 5'b01000,
        Show   = 5'b10000
    } stateT;

    // Button index 0 = btnU (load/advance), 1 = btnL (abort)
    logic [1:0]       syncMeta;
    logic [1:0]       syncLvl;
    logic [1:0]       dbLevel;
    logic [1:0]       evPulse;
    logic [CNT_W-1:0] dbCnt [2];

    logic upEv;
    logic abEv;

    stateT curState;
    stateT nextState;
    logic  loadA;
    logic  loadB;
    logic  loadOp;
    logic  capture;

    // Synchronize, debounce and turn debounced rising edges into one-cycle events
    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            syncMeta <= '0;
            syncLvl  <= '0;
            dbLevel  <= '0;
            evPulse  <= '0;
            dbCnt[0] <= '0;
            dbCnt[1] <= '0;
        end else begin
            syncMeta <= {btnL, btnU};
            syncLvl  <= syncMeta;
            evPulse  <= '0;
            for (int i = 0; i < 2; i++) begin
                if (syncLvl[i] != dbLevel[i]) begin
                    if (dbCnt[i] == CNT_MAX) begin
                        dbLevel[i] <= syncLvl[i];
                        dbCnt[i]   <= '0;
                        evPulse[i] <= syncLvl[i];
                    end else begin
                        dbCnt[i] <= dbCnt[i] + CNT_W'(1);
                    end
                end else begin
                    dbCnt[i] <= '0;
                end
            end
        end
    end

    assign upEv = evPulse[0];
    assign abEv = evPulse[1];

    // State register
    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            curState <= LoadA;
        end else begin
            curState <= nextState;
        end
    end

    // Next-state and load strobes; abort beats advance, EXEC ignores all events
    always_comb begin
        nextState = curState;
        loadA     = 1'b0;
        loadB     = 1'b0;
        loadOp    = 1'b0;
        capture   = 1'b0;
        case (curState)
            LoadA: begin
                if (abEv) begin
                    nextState = LoadA;
                end else if (upEv) begin
                    loadA     = 1'b1;
                    nextState = LoadB;
                end
            end
            LoadB: begin
                if (abEv) begin
                    nextState = LoadA;
                end else if (upEv) begin
                    loadB     = 1'b1;
                    nextState = LoadOp;
                end
            end
            LoadOp: begin
                if (abEv) begin
                    nextState = LoadA;
                end else if (upEv) begin
                    loadOp    = 1'b1;
                    nextState = Exec;
                end
            end
            Exec: begin
                capture   = 1'b1;
                nextState = Show;
            end
            Show: begin
                if (abEv || upEv) begin
                    nextState = LoadA;
                end
            end
            default: nextState = LoadA;
        endcase
    end

    // Operand, opcode and result registers; done marks the first SHOW cycle
    always_ff @(posedge clk or posedge btnC) begin
        if (btnC) begin
            A      <= '0;
            B      <= '0;
            op     <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            if (loadA) begin
                A <= sw;
            end
            if (loadB) begin
                B <= sw;
            end
            if (loadOp) begin
                op <= sw[2:0];
            end
            if (capture) begin
                result <= alu_y;
            end
            done <= capture;
        end
    end

    assign state = curState;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small behavioural ALU on alu_y.
module tb_alu_op_sequencer;

    localparam int unsigned DB = 4;

    logic       clk;
    logic       btnC;
    logic       btnU;
    logic       btnL;
    logic [3:0] sw;
    logic [4:0] alu_y;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] op;
    logic [4:0] result;
    logic       done;
    logic [4:0] state;

    int checks = 0;
    int fails  = 0;
    int upEvCnt = 0;
    int execCnt = 0;
    int doneCnt = 0;

    alu_op_sequencer #(.DB_CYCLES(DB)) dut (
        .clk(clk), .btnC(btnC), .btnU(btnU), .btnL(btnL), .sw(sw),
        .alu_y(alu_y), .A(A), .B(B), .op(op), .result(result),
        .done(done), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 0 AND, 1 OR, 2 ADD, 3 SUB (bit 4 borrow), others XOR
    always_comb begin
        case (op)
            3'd0:    alu_y = {1'b0, A & B};
            3'd1:    alu_y = {1'b0, A | B};
            3'd2:    alu_y = {1'b0, A} + {1'b0, B};
            3'd3:    alu_y = {1'b0, A} - {1'b0, B};
            default: alu_y = {1'b0, A ^ B};
        endcase
    end

    // Per-cycle event/state counters, sampled with pre-edge values
    always @(posedge clk) begin
        if (dut.upEv === 1'b1) upEvCnt++;
        if (state === 5'b01000) execCnt++;
        if (done === 1'b1) doneCnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pressU();
        btnU = 1'b1;
        tick(8);
        btnU = 1'b0;
        tick(8);
    endtask

    task automatic pressL();
        btnL = 1'b1;
        tick(8);
        btnL = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        btnC = 1'b1;
        tick(2);
        checks++; if (A !== 4'h0) begin fails++; $display("FAIL reset_A got %h exp 0", A); end
        checks++; if (B !== 4'h0) begin fails++; $display("FAIL reset_B got %h exp 0", B); end
        checks++; if (op !== 3'h0) begin fails++; $display("FAIL reset_op got %h exp 0", op); end
        checks++; if (result !== 5'h00) begin fails++; $display("FAIL reset_result got %h exp 00", result); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (state !== 5'b00001) begin fails++; $display("FAIL reset_state got %b exp 00001", state); end
        btnC = 1'b0;
        tick(2);
    endtask

    task automatic test_full_sequence();
        sw = 4'h5;
        pressU();
        checks++; if (A !== 4'h5) begin fails++; $display("FAIL full_A got %h exp 5", A); end
        checks++; if (state !== 5'b00010) begin fails++; $display("FAIL full_state_b got %b exp 00010", state); end
        sw = 4'h3;
        pressU();
        checks++; if (B !== 4'h3) begin fails++; $display("FAIL full_B got %h exp 3", B); end
        checks++; if (state !== 5'b00100) begin fails++; $display("FAIL full_state_op got %b exp 00100", state); end
        sw = 4'h2;
        execCnt = 0;
        doneCnt = 0;
        btnU = 1'b1;
        tick(7);
        checks++; if (state !== 5'b01000) begin fails++; $display("FAIL full_exec_state got %b exp 01000", state); end
        checks++; if (op !== 3'h2) begin fails++; $display("FAIL full_op got %h exp 2", op); end
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL full_done_exec got %b exp 0", done); end
        tick(1);
        checks++; if (state !== 5'b10000) begin fails++; $display("FAIL full_show_state got %b exp 10000", state); end
        checks++; if (done !== 1'b1) begin fails++; $display("FAIL full_done_pulse got %b exp 1", done); end
        checks++; if (result !== 5'h08) begin fails++; $display("FAIL full_result got %h exp 08", result); end
        tick(1);
        checks++; if (done !== 1'b0) begin fails++; $display("FAIL full_done_clear got %b exp 0", done); end
        btnU = 1'b0;
        tick(8);
        checks++; if (execCnt !== 1) begin fails++; $display("FAIL full_exec_cycles got %0d exp 1", execCnt); end
        checks++; if (doneCnt !== 1) begin fails++; $display("FAIL full_done_cycles got %0d exp 1", doneCnt); end
        checks++; if (state !== 5'b10000) begin fails++; $display("FAIL full_show_hold got %b exp 10000", state); end
    endtask

    task automatic test_abort();
        pressU();
        sw = 4'h9;
        pressU();
        sw = 4'h1;
        pressU();
        checks++; if (state !== 5'b00100) begin fails++; $display("FAIL abort_pre_state got %b exp 00100", state); end
        sw = 4'h6;
        pressL();
        checks++; if (state !== 5'b00001) begin fails++; $display("FAIL abort_state got %b exp 00001", state); end
        checks++; if (A !== 4'h9) begin fails++; $display("FAIL abort_A got %h exp 9", A); end
        checks++; if (B !== 4'h1) begin fails++; $display("FAIL abort_B got %h exp 1", B); end
        checks++; if (op !== 3'h2) begin fails++; $display("FAIL abort_op got %h exp 2", op); end
        checks++; if (result !== 5'h08) begin fails++; $display("FAIL abort_result got %h exp 08", result); end
    endtask

    task automatic test_bounce();
        sw = 4'hC;
        upEvCnt = 0;
        for (int i = 0; i < 5; i++) begin
            btnU = 1'b1;
            tick(3);
            btnU = 1'b0;
            tick(3);
        end
        checks++; if (upEvCnt !== 0) begin fails++; $display("FAIL bounce_no_event got %0d exp 0", upEvCnt); end
        btnU = 1'b1;
        tick(5);
        checks++; if (state !== 5'b00001) begin fails++; $display("FAIL bounce_early_state got %b exp 00001", state); end
        tick(5);
        checks++; if (state !== 5'b00010) begin fails++; $display("FAIL bounce_hold_state got %b exp 00010", state); end
        btnU = 1'b0;
        tick(8);
        checks++; if (upEvCnt !== 1) begin fails++; $display("FAIL bounce_event_count got %0d exp 1", upEvCnt); end
        checks++; if (A !== 4'hC) begin fails++; $display("FAIL bounce_A got %h exp C", A); end
    endtask

    task automatic test_simultaneous();
        sw = 4'h7;
        btnU = 1'b1;
        btnL = 1'b1;
        tick(10);
        btnU = 1'b0;
        btnL = 1'b0;
        tick(8);
        checks++; if (state !== 5'b00001) begin fails++; $display("FAIL simul_state got %b exp 00001", state); end
        checks++; if (B !== 4'h1) begin fails++; $display("FAIL simul_B got %h exp 1", B); end
        checks++; if (A !== 4'hC) begin fails++; $display("FAIL simul_A got %h exp C", A); end
    endtask

    task automatic test_show_wrap();
        sw = 4'h6;
        pressU();
        sw = 4'h2;
        pressU();
        sw = 4'h3;
        pressU();
        checks++; if (state !== 5'b10000) begin fails++; $display("FAIL wrap_show got %b exp 10000", state); end
        checks++; if (result !== 5'h04) begin fails++; $display("FAIL wrap_result got %h exp 04", result); end
        upEvCnt = 0;
        sw = 4'hE;
        btnU = 1'b1;
        tick(50);
        checks++; if (state !== 5'b00001) begin fails++; $display("FAIL wrap_held_state got %b exp 00001", state); end
        checks++; if (upEvCnt !== 1) begin fails++; $display("FAIL wrap_held_events got %0d exp 1", upEvCnt); end
        checks++; if (A !== 4'h6) begin fails++; $display("FAIL wrap_A_kept got %h exp 6", A); end
        btnU = 1'b0;
        tick(8);
        pressU();
        checks++; if (state !== 5'b00010) begin fails++; $display("FAIL wrap_second_state got %b exp 00010", state); end
        checks++; if (A !== 4'hE) begin fails++; $display("FAIL wrap_second_A got %h exp E", A); end
    endtask

    task automatic test_reset_mid();
        pressL();
        sw = 4'h0;
        pressU();
        sw = 4'h1;
        pressU();
        sw = 4'h3;
        pressU();
        checks++; if (result !== 5'h1F) begin fails++; $display("FAIL rmid_pre_result got %h exp 1F", result); end
        checks++; if (state !== 5'b10000) begin fails++; $display("FAIL rmid_pre_state got %b exp 10000", state); end
        sw = 4'hA;
        btnU = 1'b1;
        @(posedge clk);
        #3 btnC = 1'b1;
        #1;
        checks++; if (result !== 5'h00) begin fails++; $display("FAIL rmid_result got %h exp 00", result); end
        checks++; if (state !== 5'b00001) begin fails++; $display("FAIL rmid_state got %b exp 00001", state); end
        checks++; if ({A, B, op, done} !== 12'h000) begin fails++; $display("FAIL rmid_regs got %h exp 000", {A, B, op, done}); end
        @(negedge clk);
        btnC = 1'b0;
        upEvCnt = 0;
        tick(6);
        checks++; if (state !== 5'b00001) begin fails++; $display("FAIL rmid_wait_state got %b exp 00001", state); end
        checks++; if (upEvCnt !== 0) begin fails++; $display("FAIL rmid_wait_events got %0d exp 0", upEvCnt); end
        tick(1);
        checks++; if (state !== 5'b00010) begin fails++; $display("FAIL rmid_load_state got %b exp 00010", state); end
        checks++; if (A !== 4'hA) begin fails++; $display("FAIL rmid_load_A got %h exp A", A); end
        tick(20);
        checks++; if (upEvCnt !== 1) begin fails++; $display("FAIL rmid_event_count got %0d exp 1", upEvCnt); end
        btnU = 1'b0;
        tick(8);
    endtask

    initial begin
        btnC = 1'b1;
        btnU = 1'b0;
        btnL = 1'b0;
        sw   = 4'h0;
        test_reset();
        test_full_sequence();
        test_abort();
        test_bounce();
        test_simultaneous();
        test_show_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
